// File: rtl/sine_pkg.sv
// sine_pkg: shared types, constants and quadrant fold/rebuild helpers for the
// quarter-wave sine path. The helpers work on 32-bit containers with the table
// width passed in, so any block that uses the same table format can share them.
package sine_pkg;

  // Quadrant encoding taken from the top two phase bits.
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Scheduler states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } sched_state_t;

  // Phase accumulator width: quadrant (2) + table angle (n) + fraction.
  function automatic int phase_w(input int n, input int n_divide);
    return n + 2 + n_divide;
  endfunction

  // Offset-binary midscale for an n-bit magnitude table (output is n+1 bits).
  function automatic logic [31:0] midscale(input int n);
    return 32'd1 << n;
  endfunction

  // Quadrants 1 and 3 walk the quarter-wave table backwards.
  function automatic logic [31:0] fold_angle(input logic [1:0] q,
                                             input logic [31:0] a,
                                             input int n);
    logic [31:0] mask;
    logic [31:0] res;
    mask = (32'd1 << n) - 32'd1;
    case (q)
      QUAD_0, QUAD_2: res = a & mask;
      default:        res = ~a & mask;
    endcase
    return res;
  endfunction

  // Upper half-wave sits above midscale, lower half-wave mirrors below it.
  function automatic logic [31:0] rebuild_sample(input logic [1:0] q,
                                                 input logic [31:0] mag,
                                                 input int n);
    logic [31:0] res;
    case (q)
      QUAD_2, QUAD_3: res = midscale(n) - 32'd1 - mag;
      default:        res = midscale(n) + mag;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sine_fold.sv
// sine_fold: combinational quadrant fold of a phase into a quarter-wave table
// address, and rebuild of the full-wave offset-binary sample from the table
// magnitude. Only the integer part of the phase (quadrant + angle) is needed;
// fractional accumulator bits never reach the table.
module sine_fold
  import sine_pkg::*;
#(
  parameter int N = 7
) (
  input  logic [N+1:0] acc,
  input  logic [N-1:0] rom_data,
  output logic [N-1:0] rom_addr,
  output logic [N:0]   sample
);

  localparam int SW = N + 1;

  logic [1:0]   quad;
  logic [N-1:0] angle;

  assign quad  = acc[N+1:N];
  assign angle = acc[N-1:0];

  assign rom_addr = N'(fold_angle(quad, 32'(angle), N));
  assign sample   = SW'(rebuild_sample(quad, 32'(rom_data), N));

endmodule

// File: rtl/sine_voice_sched.sv
// sine_voice_sched: walks all voices once per sample tick, sharing a single
// registered quarter-wave table. Each voice takes an ADDR cycle (address on the
// table port) and a DATA cycle (table data back, sample registered, phase
// advanced), so a frame is 2*VOICES cycles.
module sine_voice_sched
  import sine_pkg::*;
#(
  parameter  int N        = 7,
  parameter  int N_DIVIDE = 0,
  parameter  int VOICES   = 4,
  localparam int PHASE_W  = phase_w(N, N_DIVIDE),
  localparam int VW       = $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [VW-1:0]      cfg_voice,
  input  logic [PHASE_W-1:0] cfg_inc,
  input  logic               cfg_en,
  output logic [N-1:0]       rom_addr,
  input  logic [N-1:0]       rom_data,
  output logic [N:0]         sample,
  output logic [VW-1:0]      sample_voice,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  localparam int          SW  = N + 1;
  localparam logic [N:0]  MID = SW'(midscale(N));
  localparam logic [VW-1:0] LAST_VOICE = VW'(VOICES - 1);

  // Scheduler state
  sched_state_t       state_reg;
  logic [VW-1:0]      voice_reg;
  logic [VW-1:0]      voice_next;
  logic               last_voice;
  logic               acc_step;

  // Integer phase of the voice currently on the table port; the table address
  // is a pure fold of this register.
  logic [N+1:0]       phase_reg;

  // Registered sample outputs
  logic [N:0]         sample_reg;
  logic [VW-1:0]      sample_voice_reg;
  logic               sample_valid_reg;
  logic               overrun_reg;

  // Voice register file
  logic [PHASE_W-1:0] acc_reg [VOICES];
  logic [PHASE_W-1:0] inc_reg [VOICES];
  logic [VOICES-1:0]  en_reg;

  // Per-voice decode of config writes and accumulate edges
  logic [VOICES-1:0]  cfg_hit;
  logic [VOICES-1:0]  step_hit;

  logic [N-1:0]       fold_addr;
  logic [N:0]         fold_sample;

  assign last_voice = (voice_reg == LAST_VOICE);
  assign acc_step   = (state_reg == S_DATA);

  genvar gi;
  generate
    for (gi = 0; gi < VOICES; gi++) begin : g_voice_dec
      assign cfg_hit[gi]  = cfg_we && (cfg_voice == VW'(gi));
      assign step_hit[gi] = acc_step && (voice_reg == VW'(gi));
    end
  endgenerate

  // Next voice in fixed order; wraps to 0 only when the frame is over.
  always_comb begin
    voice_next = '0;
    if (!last_voice) begin
      voice_next = voice_reg + 1'b1;
    end
  end

  sine_fold #(
    .N(N)
  ) u_fold (
    .acc      (phase_reg),
    .rom_data (rom_data),
    .rom_addr (fold_addr),
    .sample   (fold_sample)
  );

  // Config writes and phase accumulation; an en=0 write clears the phase and
  // wins over a same-edge accumulate, which itself uses the pre-write increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VOICES; i++) begin
        acc_reg[i] <= '0;
        inc_reg[i] <= '0;
      end
      en_reg <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (cfg_hit[i]) begin
          inc_reg[i] <= cfg_inc;
          en_reg[i]  <= cfg_en;
        end
        if (cfg_hit[i] && !cfg_en) begin
          acc_reg[i] <= '0;
        end else if (step_hit[i]) begin
          acc_reg[i] <= en_reg[i] ? (acc_reg[i] + inc_reg[i]) : '0;
        end
      end
    end
  end

  // Frame sequencer: IDLE -> (ADDR -> DATA) per voice -> IDLE, with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      voice_reg        <= '0;
      phase_reg        <= '0;
      sample_reg       <= MID;
      sample_voice_reg <= '0;
      sample_valid_reg <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      sample_valid_reg <= 1'b0;
      if (tick && (state_reg != S_IDLE)) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        S_IDLE: begin
          if (tick) begin
            voice_reg <= '0;
            phase_reg <= acc_reg[0][PHASE_W-1 -: N+2];
            state_reg <= S_ADDR;
          end
        end
        S_ADDR: begin
          state_reg <= S_DATA;
        end
        S_DATA: begin
          sample_reg       <= en_reg[voice_reg] ? fold_sample : MID;
          sample_voice_reg <= voice_reg;
          sample_valid_reg <= 1'b1;
          if (last_voice) begin
            state_reg <= S_IDLE;
          end else begin
            voice_reg <= voice_next;
            phase_reg <= acc_reg[voice_next][PHASE_W-1 -: N+2];
            state_reg <= S_ADDR;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_addr     = fold_addr;
  assign sample       = sample_reg;
  assign sample_voice = sample_voice_reg;
  assign sample_valid = sample_valid_reg;
  assign busy         = (state_reg != S_IDLE);
  assign overrun      = overrun_reg;

endmodule
